// File: rtl/stack_pkg.sv
// Shared types and constants for the stack arbiter.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } stk_arb_state_t;

  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic [ID_W-1:0]    o_idx_c,
  output logic               o_any_c
);

  logic [ID_W-1:0] w_pos;

  // First requester found walking from last+1 around the ring wins.
  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_pos = ID_W'((32'(i_last) + 32'(k)) % NUM_REQ);
      if (!o_any_c && i_req[w_pos]) begin
        o_any_c        = 1'b1;
        o_gnt_c[w_pos] = 1'b1;
        o_idx_c        = w_pos;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin front end serialising push/pop requests onto one shared stack.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned LEVEL_W    = 6,
  parameter int unsigned ID_W       = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ-1:0]            REQ_OP,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic                          RSP_VALID,
  output logic [ID_W-1:0]               RSP_ID,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  output logic                          RSP_ERR,
  output logic [LEVEL_W-1:0]            LEVEL,
  output logic                          BUSY,
  output logic                          STK_PUSH,
  output logic                          STK_POP,
  output logic [DATA_WIDTH-1:0]         STK_DATA_IN,
  input  logic [DATA_WIDTH-1:0]         STK_DATA_OUT,
  input  logic                          STK_FULL,
  input  logic                          STK_EMPTY
);

  stk_arb_state_t r_state, w_state_n;

  logic [NUM_REQ-1:0]    r_gnt;
  logic [ID_W-1:0]       r_last;
  logic [ID_W-1:0]       r_id;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic [LEVEL_W-1:0]    r_level;
  logic                  r_busy;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]       w_idx;
  logic                  w_any;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_reject;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req   (REQ),
    .i_last  (r_last),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_idx),
    .o_any_c (w_any)
  );

  // Stack flags, backed up by our own occupancy count so LEVEL can never wrap.
  assign w_full  = STK_FULL  | (r_level == LEVEL_W'(DEPTH));
  assign w_empty = STK_EMPTY | (r_level == '0);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != IDLE);
    end
  end

  // Next state and stack strobe decode; strobes only ever fire in ISSUE.
  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_reject  = 1'b0;
    case (r_state)
      IDLE:  if (w_any) w_state_n = ISSUE;
      ISSUE: begin
        if (r_op == OP_PUSH) begin
          if (w_full) w_reject = 1'b1;
          else        w_push   = 1'b1;
        end else begin
          if (w_empty) w_reject = 1'b1;
          else         w_pop    = 1'b1;
        end
        w_state_n = WAIT;
      end
      WAIT:    w_state_n = RESP;
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Request latch, occupancy tracking and response register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_gnt       <= '0;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_op        <= OP_POP;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_level     <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt  <= w_gnt;
            r_last <= w_idx;
            r_id   <= w_idx;
            r_op   <= REQ_OP[w_idx];
            r_data <= REQ_DATA[32'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_err  <= 1'b0;
          end
        end
        ISSUE: begin
          r_err <= w_reject;
          if (w_push)     r_level <= r_level + LEVEL_W'(1);
          else if (w_pop) r_level <= r_level - LEVEL_W'(1);
        end
        WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_data  <= (r_op == OP_POP) ? STK_DATA_OUT : r_data;
          r_rsp_err   <= r_err;
        end
        default: ;
      endcase
    end
  end

  assign GNT         = r_gnt;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_ID      = r_rsp_id;
  assign RSP_DATA    = r_rsp_data;
  assign RSP_ERR     = r_rsp_err;
  assign LEVEL       = r_level;
  assign BUSY        = r_busy;
  assign STK_PUSH    = w_push;
  assign STK_POP     = w_pop;
  assign STK_DATA_IN = w_push ? r_data : '0;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomised bench for stack_arbiter with a behavioural stack and reference model.
module tb_stack_arbiter;

  localparam int unsigned NR    = 2;
  localparam int unsigned DW    = 2;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LW    = 6;
  localparam int unsigned IW    = 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NR-1:0]   REQ;
  logic [NR-1:0]   REQ_OP;
  logic [NR*DW-1:0] REQ_DATA;
  logic [NR-1:0]   GNT;
  logic            RSP_VALID;
  logic [IW-1:0]   RSP_ID;
  logic [DW-1:0]   RSP_DATA;
  logic            RSP_ERR;
  logic [LW-1:0]   LEVEL;
  logic            BUSY;
  logic            STK_PUSH;
  logic            STK_POP;
  logic [DW-1:0]   STK_DATA_IN;
  logic [DW-1:0]   STK_DATA_OUT;
  logic            STK_FULL;
  logic            STK_EMPTY;

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  stack_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEVEL_W(LW), .ID_W(IW)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA),
    .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
    .RSP_ERR(RSP_ERR), .LEVEL(LEVEL), .BUSY(BUSY), .STK_PUSH(STK_PUSH),
    .STK_POP(STK_POP), .STK_DATA_IN(STK_DATA_IN), .STK_DATA_OUT(STK_DATA_OUT),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY)
  );

  // Behavioural stack: registered read data, reset follows RST.
  logic [DW-1:0] stk_mem[$];
  int            stk_cnt = 0;
  logic [DW-1:0] stk_dout = '0;

  always @(posedge CLK) begin
    if (RST) begin
      stk_mem.delete();
      stk_cnt  <= 0;
      stk_dout <= '0;
    end else if (STK_PUSH && stk_cnt < int'(DEPTH)) begin
      stk_mem.push_back(STK_DATA_IN);
      stk_cnt <= stk_cnt + 1;
    end else if (STK_POP && stk_cnt > 0) begin
      stk_dout <= stk_mem.pop_back();
      stk_cnt  <= stk_cnt - 1;
    end
  end

  assign STK_DATA_OUT = stk_dout;
  assign STK_FULL     = (stk_cnt == int'(DEPTH));
  assign STK_EMPTY    = (stk_cnt == 0);

  // Reference model: expected stack contents and round-robin pointer.
  logic [DW-1:0] ref_q[$];
  int            ref_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] req);
    for (int k = 1; k <= int'(NR); k++) begin
      int j;
      j = (ref_last + k) % int'(NR);
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    REQ = '0;
    repeat (2) @(negedge CLK);
    check("rst_outputs", 32'({GNT, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, LEVEL,
                              STK_PUSH, STK_POP, STK_DATA_IN}), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    ref_q.delete();
    ref_last = int'(NR) - 1;
  endtask

  // One arbitration from IDLE through the response; called at a negedge in IDLE.
  task automatic run_op(input logic [NR-1:0] req, input logic [NR-1:0] ops,
                        input logic [NR*DW-1:0] data);
    int            w;
    int            lat;
    logic          is_push;
    logic          err;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    w       = pick(req);
    is_push = ops[w];
    d       = data[w*DW +: DW];
    err     = is_push ? (ref_q.size() == int'(DEPTH)) : (ref_q.size() == 0);
    REQ      = req;
    REQ_OP   = ops;
    REQ_DATA = data;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (GNT == '0 && lat < 8);
    REQ = '0;
    check("gnt_latency", 32'(lat), 32'd1);
    if (GNT == '0) return;
    check("gnt_winner", 32'(GNT), 32'(NR'(1) << w));
    check("stk_push", 32'(STK_PUSH), 32'(is_push && !err));
    check("stk_pop", 32'(STK_POP), 32'(!is_push && !err));
    if (is_push && !err) check("stk_data_in", 32'(STK_DATA_IN), 32'(d));
    ref_last = w;
    if (err) exp_d = d;
    else if (is_push) begin
      ref_q.push_back(d);
      exp_d = d;
    end else exp_d = ref_q.pop_back();
    @(negedge CLK);
    check("rsp_early", 32'(RSP_VALID), 32'd0);
    @(negedge CLK);
    check("rsp_valid", 32'(RSP_VALID), 32'd1);
    check("rsp_id", 32'(RSP_ID), 32'(w));
    check("rsp_err", 32'(RSP_ERR), 32'(err));
    if (is_push || !err) check("rsp_data", 32'(RSP_DATA), 32'(exp_d));
    check("level", 32'(LEVEL), 32'(ref_q.size()));
    @(negedge CLK);
    check("busy_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            grants;
    int            last_c;
    int            w;
    int            seen;
    logic [NR-1:0] rq;
    RST      = 1'b1;
    REQ      = '0;
    REQ_OP   = '0;
    REQ_DATA = '0;
    @(negedge CLK);
    do_reset();

    // Requester 0 pushes 2'b10 then pops it back.
    run_op(2'b01, 2'b01, 4'b0010);
    run_op(2'b01, 2'b00, 4'b0000);

    // Requester 1 pops from an empty stack.
    run_op(2'b10, 2'b00, 4'b0000);

    // Contention: requester 0 pushes, requester 1 pops, both held high.
    REQ      = 2'b11;
    REQ_OP   = 2'b01;
    REQ_DATA = 4'b0111;
    grants   = 0;
    last_c   = -1;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      @(negedge CLK);
      if (GNT != '0) begin
        w = pick(2'b11);
        check("ct_winner", 32'(GNT), 32'(NR'(1) << w));
        if (last_c >= 0) check("ct_gap", 32'(c - last_c), 32'd4);
        last_c = c;
        if (w == 0) begin
          if (ref_q.size() < int'(DEPTH)) ref_q.push_back(REQ_DATA[DW-1:0]);
        end else begin
          if (ref_q.size() > 0) void'(ref_q.pop_back());
        end
        ref_last = w;
        grants++;
      end
    end
    REQ = '0;
    check("ct_count", 32'(grants), 32'd6);
    repeat (3) @(negedge CLK);
    check("ct_level", 32'(LEVEL), 32'(ref_q.size()));
    check("ct_busy", 32'(BUSY), 32'd0);

    // Fill to the top from random requesters, then one push too many.
    while (ref_q.size() < int'(DEPTH)) begin
      rq = NR'(1) << $urandom_range(0, NR - 1);
      run_op(rq, 2'b11, (NR*DW)'($urandom));
    end
    check("full_level", 32'(LEVEL), 32'(DEPTH));
    run_op(2'b10, 2'b11, 4'b1101);
    check("full_hold", 32'(LEVEL), 32'(DEPTH));

    // Random traffic: random request masks, ops and data.
    for (int i = 0; i < 60; i++) begin
      rq = NR'($urandom_range(1, (1 << NR) - 1));
      run_op(rq, NR'($urandom), (NR*DW)'($urandom));
    end

    // Drain and confirm pop-while-empty again at the bottom.
    while (ref_q.size() > 0) run_op(2'b01, 2'b00, 4'b0000);
    run_op(2'b01, 2'b00, 4'b0000);

    // Reset while the arbiter sits in WAIT with a push in flight.
    REQ      = 2'b01;
    REQ_OP   = 2'b01;
    REQ_DATA = 4'b0001;
    @(negedge CLK);
    check("rw_gnt", 32'(GNT), 32'd1);
    REQ = '0;
    @(negedge CLK);
    check("rw_level_pre", 32'(LEVEL), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    ref_q.delete();
    ref_last = int'(NR) - 1;
    check("rw_busy", 32'(BUSY), 32'd0);
    check("rw_level", 32'(LEVEL), 32'd0);
    check("rw_strobes", 32'({STK_PUSH, STK_POP}), 32'd0);
    seen = 0;
    repeat (4) begin
      if (RSP_VALID) seen++;
      @(negedge CLK);
    end
    check("rw_no_rsp", 32'(seen), 32'd0);

    // After reset, requester 0 has priority again.
    run_op(2'b11, 2'b11, 4'b1001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Round-robin controller that shares one `stack` instance between `NUM_REQ` requesters. It serialises push/pop requests, drives the stack's `PUSH`/`POP`/`DATA_IN` strobes and guards them with `FULL`/`EMPTY`. Each accepted request gets exactly one tagged response, carrying the popped data or an error flag. It sits between the requesting engines and the stack; the top level ties the stack's `RST_N` to `~RST`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 2: stack word width. Must match the stack.
- `DEPTH`, 32: stack depth. Must match the stack.
- `LEVEL_W`, 6: width of `LEVEL`. Must be ≥ clog2(`DEPTH`+1). Set by hand.
- `ID_W`, 1: width of `RSP_ID`. Must be ≥ clog2(`NUM_REQ`).

Ports (clock `CLK`; reset `RST` is synchronous and active-high):
- `CLK` in 1: clock.
- `RST` in 1: synchronous reset, active-high.
- `REQ` in `NUM_REQ`: request per requester. Held high until `GNT` for that requester.
- `REQ_OP` in `NUM_REQ`: per-requester op. 1 = push, 0 = pop.
- `REQ_DATA` in `NUM_REQ`×`DATA_WIDTH`: packed push data. Requester i uses slice i.
- `GNT` out `NUM_REQ`: one-hot, one-cycle grant pulse.
- `RSP_VALID` out 1: one-cycle response strobe.
- `RSP_ID` out `ID_W`: requester index that the response belongs to.
- `RSP_DATA` out `DATA_WIDTH`: for a pop, the popped word; for a push, the pushed word.
- `RSP_ERR` out 1: request rejected (push while full, or pop while empty).
- `LEVEL` out `LEVEL_W`: current stack occupancy.
- `BUSY` out 1: high whenever the state is not IDLE.
- `STK_PUSH` out 1, `STK_POP` out 1, `STK_DATA_IN` out `DATA_WIDTH`: stack controls.
- `STK_DATA_OUT` in `DATA_WIDTH`, `STK_FULL` in 1, `STK_EMPTY` in 1: stack status.

## Operation
- **States**: IDLE → ISSUE → WAIT → RESP → IDLE. No other transitions except reset.
- **IDLE**:
  - If `REQ` is nonzero, pick the winner round-robin, starting the search at `last+1` mod `NUM_REQ`.
  - Latch the winner's id, op and data; set `last` to the winner.
  - Register `GNT[winner]`=1 and go to ISSUE.
- **ISSUE**:
  - Rejected op: push with `STK_FULL`=1, or pop with `STK_EMPTY`=1. Set the error latch; assert no strobe.
  - Otherwise assert exactly one of `STK_PUSH`/`STK_POP` for this cycle only, with `STK_DATA_IN` = latched data.
  - Strobes are decoded from the state register, the latched op and the stack flags; they are never asserted outside ISSUE.
  - On an accepted op, `LEVEL` increments (push) or decrements (pop).
  - Go to WAIT.
- **WAIT**: capture `STK_DATA_OUT` into the response register for a pop; for a push, keep the latched data. Go to RESP.
- **RESP**: `RSP_VALID`=1 with `RSP_ID`, `RSP_DATA` and `RSP_ERR`. Return to IDLE.
- **Round-robin pointer**: after reset `last` = `NUM_REQ`-1, so requester 0 has first priority.
- **Arithmetic**: `LEVEL` never wraps. It saturates because rejected ops are not counted. `RSP_ERR` responses leave `LEVEL` unchanged.
- **Requester protocol**: a `REQ` still high when the arbiter returns to IDLE is treated as a new request.

## Timing
- **Reset values**: state IDLE; `GNT`=0, `RSP_VALID`=0, `RSP_ID`=0, `RSP_DATA`=0, `RSP_ERR`=0, `LEVEL`=0, `BUSY`=0, `STK_PUSH`=0, `STK_POP`=0, `STK_DATA_IN`=0.
- **Latency** (request sampled in IDLE at cycle t):
  - `GNT` high in t+1.
  - Stack strobe in t+1.
  - `RSP_VALID` in t+3.
  - Next arbitration at t+4, so throughput is one op per 4 cycles.
- **Simultaneous requests**: exactly one grant per arbitration. Losers keep `REQ` high and are served in rotation.
- **Reset mid-operation**:
  - Abandon the op; any pending response is dropped.
  - Strobes are 0 from the cycle after `RST` is sampled.
  - `LEVEL` returns to 0, consistent with the stack's reset.

## Structure
- Shared package `stack_pkg` holds:
  - state typedef `stk_arb_state_t` (IDLE, ISSUE, WAIT, RESP);
  - op constants `OP_POP`=0 and `OP_PUSH`=1.
- One sub-module, `rr_arbiter`: combinational pick from `REQ` and `last`, returning a one-hot grant and a binary index.

## Test plan
- **Reset**: hold `RST` for 2 cycles → every output is 0 and `BUSY`=0. A request sampled in the first post-reset IDLE gets `GNT` in the following cycle.
- **Single push then pop**: requester 0 pushes 2'b10 then pops.
  - Push response: `RSP_VALID` at t+3, `RSP_ID`=0, `RSP_ERR`=0, `LEVEL`=1.
  - Pop response: `RSP_DATA`=2'b10, `LEVEL`=0.
- **Pop while empty**: requester 1 pops from an empty stack → no `STK_POP`, `RSP_ERR`=1, `RSP_ID`=1, `LEVEL`=0.
- **Contention**: both requesters hold `REQ` continuously.
  - Grants alternate 0, 1, 0, 1, spaced 4 cycles apart.
  - No requester waits more than `NUM_REQ` arbitrations.
- **Full**: 32 pushes, then a 33rd push.
  - `LEVEL`=32 after the 32nd.
  - The 33rd gives `RSP_ERR`=1, no `STK_PUSH`, and `LEVEL` stays 32.
- **Reset in WAIT**: assert `RST` during WAIT → no `RSP_VALID`, state IDLE, `LEVEL`=0.
